irrigation_ctrl: RTL and testbench

Irrigation sequencing FSM that sits directly upstream of the countdown timer/display stage. It filters the tank-level probes and the soil-moisture input, then selects sprinkler or drip mode. It loads the timer with a BCD minutes preset, runs it, and consumes the timer's reach-zero flag to close the cycle, driving the valve and alarm outputs.

---
 rtl/irrigation_ctrl_pkg.sv | 44 ++++
 rtl/irrigation_ctrl_if.sv | 18 +
 rtl/irrigation_ctrl_input_filter.sv | 47 ++++
 rtl/irrigation_ctrl.sv | 169 ++++++++++++++++
 tb/tb_irrigation_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/irrigation_ctrl_pkg.sv
// Shared types and helpers for the irrigation controller.
// Contents: state encoding (also driven on state_o), sensor vector and BCD
// preset payloads, binary-to-BCD conversion and probe plausibility check.
package irrig_pkg;

  localparam int unsigned MIN_W   = 6;   // minutes preset width (0..59)
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ARM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_FILL  = 3'd5,
    ST_ERROR = 3'd6
  } state_e;

  typedef struct packed {
    logic lvl_h;
    logic lvl_m;
    logic lvl_l;
    logic soil_dry;
  } sens_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  // 0..59 minutes to two BCD digits
  function automatic bcd_t bin2bcd(input logic [MIN_W-1:0] bin);
    bcd_t r;
    r.tens  = 4'(bin / MIN_W'(10));
    r.units = 4'(bin % MIN_W'(10));
    return r;
  endfunction

  // A wet probe above a dry one is physically impossible
  function automatic logic probe_invalid(input sens_t v);
    return (v.lvl_h & ~v.lvl_m) | (v.lvl_m & ~v.lvl_l);
  endfunction

endpackage

// File: rtl/irrigation_ctrl_if.sv
// Handshake between the irrigation sequencer and the countdown timer.
//   tmr_load  : one-cycle preset strobe (sequencer -> timer)
//   tmr_tens  : BCD minutes tens digit of the preset
//   tmr_units : BCD minutes units digit of the preset
//   tmr_run   : count enable
//   tmr_zero  : timer reached 00:00 (timer -> sequencer)
interface irrigation_ctrl_if;
  logic       tmr_load;
  logic [3:0] tmr_tens;
  logic [3:0] tmr_units;
  logic       tmr_run;
  logic       tmr_zero;

  modport master (output tmr_load, tmr_tens, tmr_units, tmr_run,
                  input  tmr_zero);
  modport slave  (input  tmr_load, tmr_tens, tmr_units, tmr_run,
                  output tmr_zero);
endinterface

// File: rtl/irrigation_ctrl_input_filter.sv
// Sensor conditioning: 2-flop synchronizer on the raw probe/soil vector and
// a saturating stability counter.
//   clk, rst  : clock, synchronous active-high reset
//   raw       : asynchronous sensor vector
//   vec_c     : last vector that was held for SETTLE_CYC cycles
//   stable_c  : the synchronized vector has been constant for SETTLE_CYC cycles
module irrig_input_filter
  import irrig_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  sens_t raw,
  output sens_t vec_c,
  output logic  stable_c
);

  localparam int unsigned CW = 8;

  sens_t         sync1, sync2, last_q;
  logic [CW-1:0] cnt;

  assign stable_c = (cnt == CW'(SETTLE_CYC));
  // Present the freshly stable vector in the same cycle the flag rises
  assign vec_c    = stable_c ? sync2 : last_q;

  // Synchronizer, stability counter and last-stable capture
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      last_q <= '0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync1 != sync2)
        cnt <= '0;
      else if (!stable_c)
        cnt <= cnt + CW'(1);
      if (stable_c)
        last_q <= sync2;
    end
  end

endmodule

// File: rtl/irrigation_ctrl.sv
// Irrigation sequencer in front of the countdown timer/display stage.
// Filters the tank probes and soil input, picks sprinkler (tank high) or drip
// mode, loads the timer with a BCD minutes preset, runs it and closes the
// cycle on the timer's reach-zero flag.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   lvl_h, lvl_m, lvl_l      : tank probes, 1 = water present (async)
//   soil_dry                 : 1 = soil needs water (async)
//   tmr                      : timer handshake (load/preset/run out, zero in)
//   valve_spr, valve_drip    : irrigation valves
//   fill_valve               : tank refill valve
//   alarm                    : probe fault, or tank low without refill
//   state_o                  : current state encoding
// Build option: define IRRIG_FILL_EN to include the tank refill state; without
// it fill_valve stays 0 and a low tank raises alarm while idle.
module irrigation_ctrl
  import irrig_pkg::*;
#(
  parameter int unsigned SPR_MIN    = 5,
  parameter int unsigned DRIP_MIN   = 15,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned PAUSE_CYC  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lvl_h,
  input  logic                lvl_m,
  input  logic                lvl_l,
  input  logic                soil_dry,
  irrigation_ctrl_if.master   tmr,
  output logic                valve_spr,
  output logic                valve_drip,
  output logic                fill_valve,
  output logic                alarm,
  output logic [STATE_W-1:0]  state_o
);

  localparam int unsigned PW = 16;

  sens_t         raw, vec_c;
  logic          stable_c, bad_c;
  state_e        state, state_n;
  logic          mode_spr, mode_spr_n;      // 1 = sprinkler, 0 = drip
  logic [PW-1:0] pcnt, pcnt_n;
  logic [MIN_W-1:0] sel_min_n;
  logic          preset_zero_c;
  bcd_t          bcd_q;
  logic          load_n, run_n, spr_n, drip_n, fill_n, alarm_n;

  assign raw = '{lvl_h: lvl_h, lvl_m: lvl_m, lvl_l: lvl_l, soil_dry: soil_dry};

  irrig_input_filter #(.SETTLE_CYC(SETTLE_CYC)) u_filter (
    .clk      (clk),
    .rst      (rst),
    .raw      (raw),
    .vec_c    (vec_c),
    .stable_c (stable_c)
  );

  assign bad_c         = stable_c & probe_invalid(vec_c);
  assign preset_zero_c = mode_spr ? (SPR_MIN == 0) : (DRIP_MIN == 0);
  assign sel_min_n     = mode_spr_n ? MIN_W'(SPR_MIN) : MIN_W'(DRIP_MIN);

  // Next state, mode latch, pause counter and next-cycle outputs
  always_comb begin
    state_n    = state;
    mode_spr_n = mode_spr;
    pcnt_n     = '0;

    case (state)
      ST_IDLE: begin
        if (stable_c && vec_c.soil_dry && vec_c.lvl_m) begin
          state_n    = ST_LOAD;
          mode_spr_n = vec_c.lvl_h;
        end
`ifdef IRRIG_FILL_EN
        else if (stable_c && !vec_c.lvl_m) begin
          state_n = ST_FILL;
        end
`endif
      end
      ST_LOAD: state_n = preset_zero_c ? ST_PAUSE : ST_ARM;
      ST_ARM:  state_n = ST_RUN;
      ST_RUN: begin
        if (stable_c && !vec_c.lvl_m) begin
`ifdef IRRIG_FILL_EN
          state_n = ST_FILL;
`else
          state_n = ST_PAUSE;
`endif
        end else if (stable_c && !vec_c.soil_dry) begin
          state_n = ST_PAUSE;
        end else if (tmr.tmr_zero) begin
          state_n = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pcnt == PW'(PAUSE_CYC - 1))
          state_n = ST_IDLE;
        else
          pcnt_n = pcnt + PW'(1);
      end
      ST_FILL: begin
`ifdef IRRIG_FILL_EN
        if (stable_c && vec_c.lvl_h)
          state_n = ST_IDLE;
`else
        state_n = ST_IDLE;
`endif
      end
      ST_ERROR: begin
        if (stable_c && !probe_invalid(vec_c))
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    // A settled implausible probe pattern overrides everything
    if (bad_c)
      state_n = ST_ERROR;

    load_n = (state_n == ST_LOAD);
    run_n  = (state_n == ST_ARM) || (state_n == ST_RUN);
    spr_n  = run_n &  mode_spr_n;
    drip_n = run_n & ~mode_spr_n;
`ifdef IRRIG_FILL_EN
    fill_n  = (state_n == ST_FILL);
    alarm_n = (state_n == ST_ERROR);
`else
    fill_n  = 1'b0;
    alarm_n = (state_n == ST_ERROR) ||
              ((state_n == ST_IDLE) && stable_c && !vec_c.lvl_m);
`endif
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      mode_spr     <= 1'b0;
      pcnt         <= '0;
      bcd_q        <= '0;
      tmr.tmr_load <= 1'b0;
      tmr.tmr_run  <= 1'b0;
      valve_spr    <= 1'b0;
      valve_drip   <= 1'b0;
      fill_valve   <= 1'b0;
      alarm        <= 1'b0;
    end else begin
      state        <= state_n;
      mode_spr     <= mode_spr_n;
      pcnt         <= pcnt_n;
      tmr.tmr_load <= load_n;
      tmr.tmr_run  <= run_n;
      valve_spr    <= spr_n;
      valve_drip   <= drip_n;
      fill_valve   <= fill_n;
      alarm        <= alarm_n;
      // Preset is held until the next load
      if (state_n == ST_LOAD)
        bcd_q <= bin2bcd(sel_min_n);
    end
  end

  assign tmr.tmr_tens  = bcd_q.tens;
  assign tmr.tmr_units = bcd_q.units;
  assign state_o       = state;

endmodule

// File: tb/tb_irrigation_ctrl.sv
// Directed bench for irrigation_ctrl: default-parameter instance plus a
// second instance with a zero sprinkler preset sharing the sensor inputs.
// Honours IRRIG_FILL_EN for the low-tank scenario.
module tb_irrigation_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_FILL  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  logic clk = 1'b0;
  logic rst;
  logic lvl_h, lvl_m, lvl_l, soil_dry;

  logic       valve_spr, valve_drip, fill_valve, alarm;
  logic [2:0] state_o;
  logic       z_valve_spr, z_valve_drip, z_fill_valve, z_alarm;
  logic [2:0] z_state_o;

  int n_cmp = 0;
  int n_err = 0;
  logic z_mon = 1'b0;
  logic z_run_seen = 1'b0;

  irrigation_ctrl_if tif ();
  irrigation_ctrl_if zif ();

  irrigation_ctrl u_dut (
    .clk(clk), .rst(rst),
    .lvl_h(lvl_h), .lvl_m(lvl_m), .lvl_l(lvl_l), .soil_dry(soil_dry),
    .tmr(tif.master),
    .valve_spr(valve_spr), .valve_drip(valve_drip),
    .fill_valve(fill_valve), .alarm(alarm), .state_o(state_o)
  );

  irrigation_ctrl #(.SPR_MIN(0)) u_zero (
    .clk(clk), .rst(rst),
    .lvl_h(lvl_h), .lvl_m(lvl_m), .lvl_l(lvl_l), .soil_dry(soil_dry),
    .tmr(zif.master),
    .valve_spr(z_valve_spr), .valve_drip(z_valve_drip),
    .fill_valve(z_fill_valve), .alarm(z_alarm), .state_o(z_state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (z_mon && zif.tmr_run === 1'b1) z_run_seen = 1'b1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int maxc);
    int i;
    i = 0;
    while (state_o !== s && i < maxc) begin
      step(1);
      i++;
    end
    chk(tag, 8'(state_o), 8'(s));
  endtask

  initial begin
    rst = 1'b1;
    lvl_h = 1'b1; lvl_m = 1'b1; lvl_l = 1'b1; soil_dry = 1'b1;
    tif.tmr_zero = 1'b0;
    zif.tmr_zero = 1'b0;
    step(3);

    // reset values
    chk("rst_state", 8'(state_o), 8'(S_IDLE));
    chk("rst_load",  8'(tif.tmr_load), 8'd0);
    chk("rst_run",   8'(tif.tmr_run), 8'd0);
    chk("rst_tens",  8'(tif.tmr_tens), 8'd0);
    chk("rst_units", 8'(tif.tmr_units), 8'd0);
    chk("rst_valves", 8'({valve_spr, valve_drip, fill_valve, alarm}), 8'd0);
    chk("rst_z_state", 8'(z_state_o), 8'(S_IDLE));

    rst = 1'b0;
    z_mon = 1'b1;

    // sprinkler cycle closed by tmr_zero
    wait_state("spr_load", S_LOAD, 30);
    chk("spr_load_pulse", 8'(tif.tmr_load), 8'd1);
    chk("spr_tens",  8'(tif.tmr_tens), 8'd0);
    chk("spr_units", 8'(tif.tmr_units), 8'd5);
    chk("spr_run_pre", 8'(tif.tmr_run), 8'd0);
    chk("z_load_pulse", 8'(zif.tmr_load), 8'd1);
    chk("z_tens",  8'(zif.tmr_tens), 8'd0);
    chk("z_units", 8'(zif.tmr_units), 8'd0);
    step(1);
    chk("spr_arm", 8'(state_o), 8'(S_ARM));
    chk("spr_load_drop", 8'(tif.tmr_load), 8'd0);
    chk("spr_run", 8'(tif.tmr_run), 8'd1);
    chk("spr_valve", 8'(valve_spr), 8'd1);
    chk("spr_no_drip", 8'(valve_drip), 8'd0);
    chk("z_pause", 8'(z_state_o), 8'(S_PAUSE));
    step(1);
    chk("spr_run_state", 8'(state_o), 8'(S_RUN));
    step(3);
    tif.tmr_zero = 1'b1;
    step(1);
    tif.tmr_zero = 1'b0;
    chk("zero_pause", 8'(state_o), 8'(S_PAUSE));
    chk("zero_valve_off", 8'(valve_spr), 8'd0);
    chk("zero_run_off", 8'(tif.tmr_run), 8'd0);
    step(15);
    chk("pause_len_15", 8'(state_o), 8'(S_PAUSE));
    step(1);
    chk("pause_len_16", 8'(state_o), 8'(S_IDLE));

    // second sprinkler cycle; tank drops below high while running
    wait_state("spr2_run", S_RUN, 10);
    z_mon = 1'b0;
    chk("z_never_ran", 8'(z_run_seen), 8'd0);
    lvl_h = 1'b0;
    step(10);
    chk("spr2_still_run", 8'(state_o), 8'(S_RUN));
    chk("spr2_mode_kept", 8'(valve_spr), 8'd1);
    tif.tmr_zero = 1'b1;
    step(1);
    tif.tmr_zero = 1'b0;
    chk("spr2_pause", 8'(state_o), 8'(S_PAUSE));

    // drip cycle
    wait_state("drip_idle", S_IDLE, 20);
    wait_state("drip_load", S_LOAD, 5);
    chk("drip_tens",  8'(tif.tmr_tens), 8'd1);
    chk("drip_units", 8'(tif.tmr_units), 8'd5);
    step(1);
    chk("drip_valve", 8'(valve_drip), 8'd1);
    chk("drip_no_spr", 8'(valve_spr), 8'd0);
    chk("drip_run", 8'(tif.tmr_run), 8'd1);
    step(1);
    chk("drip_run_state", 8'(state_o), 8'(S_RUN));

    // short soil glitch is filtered out
    soil_dry = 1'b0;
    step(2);
    soil_dry = 1'b1;
    step(10);
    chk("glitch_run", 8'(state_o), 8'(S_RUN));
    chk("glitch_valve", 8'(valve_drip), 8'd1);

    // settled wet soil stops early, 2 + SETTLE_CYC + 1 cycles later
    soil_dry = 1'b0;
    step(6);
    chk("wet_lat_6", 8'(state_o), 8'(S_RUN));
    step(1);
    chk("wet_lat_7", 8'(state_o), 8'(S_PAUSE));
    chk("wet_valve_off", 8'(valve_drip), 8'd0);
    chk("wet_run_off", 8'(tif.tmr_run), 8'd0);
    wait_state("wet_idle", S_IDLE, 20);
    step(3);
    chk("wet_stay_idle", 8'(state_o), 8'(S_IDLE));
    chk("wet_no_alarm", 8'(alarm), 8'd0);
    chk("hold_tens",  8'(tif.tmr_tens), 8'd1);
    chk("hold_units", 8'(tif.tmr_units), 8'd5);

    // tank drops below middle probe during a drip run
    soil_dry = 1'b1;
    wait_state("low_run", S_RUN, 20);
    lvl_m = 1'b0;
`ifdef IRRIG_FILL_EN
    wait_state("low_fill", S_FILL, 15);
    chk("low_fill_valve", 8'(fill_valve), 8'd1);
    chk("low_drip_off", 8'(valve_drip), 8'd0);
    chk("low_run_off", 8'(tif.tmr_run), 8'd0);
    lvl_h = 1'b1; lvl_m = 1'b1;
    wait_state("fill_done_idle", S_IDLE, 15);
    chk("fill_valve_off", 8'(fill_valve), 8'd0);
    wait_state("refill_load", S_LOAD, 5);
`else
    wait_state("low_pause", S_PAUSE, 15);
    chk("low_drip_off", 8'(valve_drip), 8'd0);
    chk("low_fill_tied", 8'(fill_valve), 8'd0);
    wait_state("low_idle", S_IDLE, 20);
    chk("low_alarm", 8'(alarm), 8'd1);
    step(3);
    chk("low_wait_idle", 8'(state_o), 8'(S_IDLE));
    chk("low_alarm_held", 8'(alarm), 8'd1);
    lvl_h = 1'b1; lvl_m = 1'b1;
    wait_state("refill_load", S_LOAD, 15);
    chk("refill_alarm_off", 8'(alarm), 8'd0);
`endif
    chk("refill_tens",  8'(tif.tmr_tens), 8'd0);
    chk("refill_units", 8'(tif.tmr_units), 8'd5);

    // implausible probes during RUN, then during IDLE
    wait_state("err_run", S_RUN, 5);
    lvl_m = 1'b0;
    wait_state("err_from_run", S_ERROR, 15);
    chk("err_alarm", 8'(alarm), 8'd1);
    chk("err_valves", 8'({valve_spr, valve_drip, fill_valve, tif.tmr_run}), 8'd0);
    lvl_m = 1'b1; soil_dry = 1'b0;
    wait_state("err_clear_idle", S_IDLE, 15);
    chk("err_clear_alarm", 8'(alarm), 8'd0);
    lvl_m = 1'b0;
    wait_state("err_from_idle", S_ERROR, 15);
    chk("err_idle_alarm", 8'(alarm), 8'd1);
    lvl_m = 1'b1;
    wait_state("err2_clear_idle", S_IDLE, 15);

    // reset while running
    soil_dry = 1'b1;
    wait_state("rst_run", S_RUN, 20);
    chk("rst_run_valve", 8'(valve_spr), 8'd1);
    rst = 1'b1;
    step(1);
    chk("midrst_state", 8'(state_o), 8'(S_IDLE));
    chk("midrst_valves", 8'({valve_spr, valve_drip, fill_valve, alarm}), 8'd0);
    chk("midrst_tmr", 8'({tif.tmr_load, tif.tmr_run}), 8'd0);
    chk("midrst_bcd", 8'({tif.tmr_tens, tif.tmr_units}), 8'd0);
    rst = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
